auto_pilot_ctrl: RTL

Parametrised wall-following navigation FSM for the car, selectable right-hand or left-hand rule. Replaces the fixed-timing auto-driving controller. Driven by an external tick strobe instead of an internal divider. Emits one-hot motion commands plus barrier place/destroy pulses to the manual/auto output mux, with a configurable destroy budget.

---
 rtl/auto_pilot_pkg.sv | 32 +++
 rtl/auto_pilot_ctrl_pulse_window.sv | 20 ++
 rtl/auto_pilot_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/auto_pilot_pkg.sv
// Shared definitions for the wall-following auto-pilot.
//   state_t   : FSM state codes (also driven out on state_o for debug LEDs)
//   MOT_*     : motion codes, bit order {forward, backward, left, right}
//   DET_*     : bit positions in the detector bundle {back, front, left, right}
package auto_pilot_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      TURN_P   = 3'b001,
      TURN_A   = 3'b010,
      STRAIGHT = 3'b011,
      UTURN    = 3'b100,
      CONFIRM  = 3'b101,
      CLEAR    = 3'b110
   } state_t;

   localparam logic [3:0] MOT_NONE  = 4'b0000;
   localparam logic [3:0] MOT_FWD   = 4'b1000;
   localparam logic [3:0] MOT_LEFT  = 4'b0010;
   localparam logic [3:0] MOT_RIGHT = 4'b0001;

   localparam int DET_RIGHT = 0;
   localparam int DET_LEFT  = 1;
   localparam int DET_FRONT = 2;
   localparam int DET_BACK  = 3;

   // Turn command toward the left side when 'left' is set, else right.
   function automatic logic [3:0] turn_code(input logic left);
      return left ? MOT_LEFT : MOT_RIGHT;
   endfunction

endpackage

// File: rtl/auto_pilot_ctrl_pulse_window.sv
// Count-window decoder used for the place and destroy pulses.
//   cnt   : current (next-state) tick count
//   start : first count value inside the window
//   width : number of counts in the window
//   arm   : window only fires while armed
//   hit   : 1 while arm && start <= cnt < start+width
module pulse_window #(
   parameter int CNT_W = 8
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] start,
   input  logic [CNT_W-1:0] width,
   input  logic             arm,
   output logic             hit
);

   // Subtract instead of adding start+width so the upper bound cannot overflow.
   assign hit = arm && (cnt >= start) && ((cnt - start) < width);

endmodule

// File: rtl/auto_pilot_ctrl.sv
// Wall-following navigation FSM (right- or left-hand rule), advanced by an
// external tick strobe. All outputs are registered from the next state so a
// new state's commands appear on the edge that enters it.
//   clk, reset             : clock, synchronous active-high reset
//   tick, enable           : advance strobe, auto-mode enable
//   hand_sel               : 0 = right-hand rule, 1 = left-hand (latched leaving IDLE)
//   *_detector             : 1 = obstacle on that side
//   move_*/turn_*          : one-hot motion commands (move_backward unused, always 0)
//   place/destroy_barrier_signal : pulses to the output mux
//   state_o, destroys_left : debug state code, remaining destroy budget
module auto_pilot_ctrl
   import auto_pilot_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int TURN_TICKS     = 90,
   parameter int UTURN_TICKS    = 180,
   parameter int CLEAR_TICKS    = 40,
   parameter int CONFIRM_TICKS  = 8,
   parameter int BEACON_DELAY   = 75,
   parameter int PULSE_TICKS    = 5,
   parameter int DESTROY_WAIT   = 50,
   parameter int DESTROY_BUDGET = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             enable,
   input  logic             hand_sel,
   input  logic             front_detector,
   input  logic             back_detector,
   input  logic             left_detector,
   input  logic             right_detector,
   output logic             move_forward,
   output logic             move_backward,
   output logic             turn_left,
   output logic             turn_right,
   output logic             place_barrier_signal,
   output logic             destroy_barrier_signal,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] destroys_left
);

   localparam int CNT_LIM = 1 << CNT_W;

   if (TURN_TICKS >= CNT_LIM || UTURN_TICKS >= CNT_LIM || CLEAR_TICKS >= CNT_LIM ||
       CONFIRM_TICKS >= CNT_LIM || BEACON_DELAY >= CNT_LIM || PULSE_TICKS >= CNT_LIM ||
       DESTROY_WAIT >= CNT_LIM || DESTROY_BUDGET >= CNT_LIM) begin : g_bad_param
      $error("auto_pilot_ctrl: tick constant does not fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] TURN_C  = CNT_W'(TURN_TICKS);
   localparam logic [CNT_W-1:0] UTURN_C = CNT_W'(UTURN_TICKS);
   localparam logic [CNT_W-1:0] CLR_C   = CNT_W'(CLEAR_TICKS);
   localparam logic [CNT_W-1:0] CONF_C  = CNT_W'(CONFIRM_TICKS);
   localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(DESTROY_WAIT);
   localparam logic [CNT_W-1:0] BD_C    = CNT_W'(BEACON_DELAY);
   localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PULSE_TICKS);
   localparam logic [CNT_W:0]   BEND_C  = (CNT_W+1)'(BEACON_DELAY + PULSE_TICKS);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [CNT_W-1:0] dl_n;
   logic             hand_q, hand_eff;
   logic             u_flag, u_n, no_flag, no_n, bp, bp_n;
   logic             adv;
   logic [3:0]       det, mot_n;
   logic             f_blk, b_blk, p_blk, a_blk;
   logic             place_hit, destroy_hit;

   assign det = {back_detector, front_detector, left_detector, right_detector};

   // The hand is still live in IDLE so the very first move already uses it.
   assign hand_eff = (state == IDLE) ? hand_sel : hand_q;
   assign f_blk    = det[DET_FRONT];
   assign b_blk    = det[DET_BACK];
   assign p_blk    = hand_eff ? det[DET_LEFT]  : det[DET_RIGHT];
   assign a_blk    = hand_eff ? det[DET_RIGHT] : det[DET_LEFT];

   assign adv      = tick & enable;
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Durations are compared against the incremented count, so a state entered
   // at cnt=0 is held for exactly N ticks before leaving.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      u_n     = u_flag;
      no_n    = no_flag;
      bp_n    = bp;
      dl_n    = destroys_left;
      if (adv) begin
         cnt_n = cnt_inc;
         case (state)
            IDLE: begin
               if (f_blk && p_blk && a_blk && !b_blk) begin
                  state_n = UTURN;    cnt_n = '0; no_n = 1'b1;
               end else begin
                  state_n = STRAIGHT; cnt_n = CLR_C;
               end
            end
            STRAIGHT: begin
               if (cnt_inc >= CLR_C && !p_blk) begin
                  state_n = TURN_P;  cnt_n = '0; u_n = 1'b0;
               end else if (f_blk) begin
                  state_n = CONFIRM; cnt_n = '0;
               end
            end
            CONFIRM: begin
               if (cnt_inc >= CONF_C) begin
                  cnt_n = '0;
                  if (!p_blk) begin
                     state_n = TURN_P; u_n = 1'b0;
                  end else if (!f_blk) begin
                     state_n = STRAIGHT; cnt_n = CLR_C;
                  end else if (!a_blk) begin
                     state_n = TURN_A;
                  end else if (u_flag && destroys_left != '0) begin
                     state_n = CLEAR;
                  end else begin
                     state_n = UTURN;
                  end
               end
            end
            TURN_P: begin
               if (cnt_inc >= TURN_C) begin
                  state_n = STRAIGHT; cnt_n = '0; bp_n = 1'b1;
               end
            end
            TURN_A: begin
               if (cnt_inc >= TURN_C) begin
                  state_n = STRAIGHT; cnt_n = '0;
               end
            end
            UTURN: begin
               if (cnt_inc >= UTURN_C) begin
                  state_n = STRAIGHT; cnt_n = '0;
                  if (!no_flag) u_n = 1'b1;
                  no_n = 1'b0;
               end
            end
            CLEAR: begin
               if (cnt_inc >= WAIT_C) begin
                  state_n = STRAIGHT; cnt_n = CLR_C; u_n = 1'b0;
                  if (destroys_left != '0) dl_n = destroys_left - CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE; cnt_n = '0;
            end
         endcase
      end
      // Beacon dies on leaving STRAIGHT or once its window has passed.
      if (state_n != STRAIGHT || {1'b0, cnt_n} >= BEND_C) bp_n = 1'b0;
   end

   always_comb begin
      mot_n = MOT_NONE;
      case (state_n)
         STRAIGHT:      mot_n = MOT_FWD;
         TURN_P, UTURN: mot_n = turn_code(hand_eff);
         TURN_A:        mot_n = turn_code(!hand_eff);
         default:       mot_n = MOT_NONE;
      endcase
   end

   pulse_window #(.CNT_W(CNT_W)) u_place (
      .cnt   (cnt_n),
      .start (BD_C),
      .width (PW_C),
      .arm   (bp_n && state_n == STRAIGHT),
      .hit   (place_hit)
   );

   pulse_window #(.CNT_W(CNT_W)) u_destroy (
      .cnt   (cnt_n),
      .start (PW_C),
      .width (PW_C),
      .arm   (state_n == CLEAR),
      .hit   (destroy_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= IDLE;
         cnt                    <= '0;
         hand_q                 <= 1'b0;
         u_flag                 <= 1'b0;
         no_flag                <= 1'b0;
         bp                     <= 1'b0;
         destroys_left          <= CNT_W'(DESTROY_BUDGET);
         move_forward           <= 1'b0;
         move_backward          <= 1'b0;
         turn_left              <= 1'b0;
         turn_right             <= 1'b0;
         place_barrier_signal   <= 1'b0;
         destroy_barrier_signal <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         u_flag        <= u_n;
         no_flag       <= no_n;
         bp            <= bp_n;
         destroys_left <= dl_n;
         if (adv && state == IDLE) hand_q <= hand_sel;
         // Disabled: outputs go quiet but the FSM keeps its place.
         if (enable) begin
            {move_forward, move_backward, turn_left, turn_right} <= mot_n;
            place_barrier_signal   <= place_hit;
            destroy_barrier_signal <= destroy_hit;
         end else begin
            {move_forward, move_backward, turn_left, turn_right} <= MOT_NONE;
            place_barrier_signal   <= 1'b0;
            destroy_barrier_signal <= 1'b0;
         end
      end
   end

   assign state_o = state;

endmodule
